// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush sequencer.
// State codes stay plain localparams so older code that compares raw bits keeps working.
package pipeline_ctrl_pkg;

   localparam logic [0:0] RUN     = 1'b0;
   localparam logic [0:0] MEMWAIT = 1'b1;

   localparam logic [4:0] REG_ZERO = 5'd0;

   localparam int unsigned MEM_LAT_MIN = 1;
   localparam int unsigned MEM_LAT_MAX = 16;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: the load in EX targets a register the ID instruction reads.
// Register 0 is hard-wired, so it never creates a dependency.
module hazard_detect
   import pipeline_ctrl_pkg::*;
(
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rs,
   input  logic       id_uses_rt,
   input  logic       ex_memread,
   input  logic [4:0] ex_rd,
   output logic       hazard
);

   logic rs_match;
   logic rt_match;

   always_comb begin
      rs_match = id_uses_rs && (id_rs == ex_rd);
      rt_match = id_uses_rt && (id_rt == ex_rd);
      hazard   = ex_memread && (ex_rd != REG_ZERO) && (rs_match || rt_match);
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory freeze, branch flush, load-use bubble,
// plus saturating stall and flush counters.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned MEM_LAT = 2,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rd,
   input  logic             ex_branch_taken,
   input  logic             mem_access,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             idex_we,
   output logic             exmem_we,
   output logic             memwb_we,
   output logic             ifid_clr,
   output logic             idex_clr,
   output logic             hazard_bubble,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
      $error("pipeline_ctrl: MEM_LAT out of range");
   end

   // Cycles still to wait after the first frozen cycle of an access.
   localparam logic [3:0] WAIT_INIT = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [0:0]       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] flush_count_q, flush_count_d;
   logic             load_use;
   logic             flush_applied;

   hazard_detect u_hazard_detect (
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_uses_rs (id_uses_rs),
      .id_uses_rt (id_uses_rt),
      .ex_memread (ex_memread),
      .ex_rd      (ex_rd),
      .hazard     (load_use)
   );

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pc_we         = 1'b1;
      ifid_we       = 1'b1;
      idex_we       = 1'b1;
      exmem_we      = 1'b1;
      memwb_we      = 1'b1;
      ifid_clr      = 1'b0;
      idex_clr      = 1'b0;
      hazard_bubble = 1'b0;
      flush_applied = 1'b0;

      if (reset) begin
         {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b00000;
         ifid_clr = 1'b1;
         idex_clr = 1'b1;
         state_d  = RUN;
         cnt_d    = 4'd0;
      end else if (state_q == RUN && mem_access && MEM_LAT > 1) begin
         {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b00000;
         state_d = MEMWAIT;
         cnt_d   = WAIT_INIT;
      end else if (state_q == MEMWAIT && cnt_q != 4'd0) begin
         {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b00000;
         cnt_d = cnt_q - 4'd1;
      end else begin
         // RUN without an access, or the MEMWAIT release cycle.
         state_d = RUN;
         if (ex_branch_taken) begin
            ifid_we       = 1'b0;
            idex_we       = 1'b0;
            ifid_clr      = 1'b1;
            idex_clr      = 1'b1;
            flush_applied = 1'b1;
         end else if (load_use) begin
            pc_we         = 1'b0;
            ifid_we       = 1'b0;
            idex_clr      = 1'b1;
            hazard_bubble = 1'b1;
         end
      end
   end

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (reset) begin
         stall_cycles_d = '0;
         flush_count_d  = '0;
      end else begin
         if (!pc_we && stall_cycles_q != CNT_MAX) begin
            stall_cycles_d = stall_cycles_q + CNT_ONE;
         end
         if (flush_applied && flush_count_q != CNT_MAX) begin
            flush_count_d = flush_count_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl against an access-age based reference model.
module tb_pipeline_ctrl;

   localparam int unsigned MEM_LAT = 4;
   localparam int unsigned CNT_W   = 4;

   logic             clk;
   logic             reset;
   logic [4:0]       id_rs, id_rt, ex_rd;
   logic             id_uses_rs, id_uses_rt, ex_memread, ex_branch_taken, mem_access;
   logic             pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_clr, idex_clr;
   logic             hazard_bubble;
   logic [CNT_W-1:0] stall_cycles, flush_count;

   int checks = 0;
   int errors = 0;

   // Reference model state: is an access sitting in MEM, and for how many cycles so far.
   bit               m_in_access = 0;
   int               m_age = 0;
   logic [CNT_W-1:0] m_stall = '0;
   logic [CNT_W-1:0] m_flush = '0;

   pipeline_ctrl #(
      .MEM_LAT (MEM_LAT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_uses_rs      (id_uses_rs),
      .id_uses_rt      (id_uses_rt),
      .ex_memread      (ex_memread),
      .ex_rd           (ex_rd),
      .ex_branch_taken (ex_branch_taken),
      .mem_access      (mem_access),
      .pc_we           (pc_we),
      .ifid_we         (ifid_we),
      .idex_we         (idex_we),
      .exmem_we        (exmem_we),
      .memwb_we        (memwb_we),
      .ifid_clr        (ifid_clr),
      .idex_clr        (idex_clr),
      .hazard_bubble   (hazard_bubble),
      .stall_cycles    (stall_cycles),
      .flush_count     (flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] act_outs();
      return {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_clr, idex_clr, hazard_bubble};
   endfunction

   function automatic bit m_frozen();
      if (m_in_access) return (m_age < int'(MEM_LAT) - 1);
      return mem_access && (MEM_LAT > 1);
   endfunction

   function automatic bit m_hazard();
      bit rs_dep = id_uses_rs && (id_rs == ex_rd);
      bit rt_dep = id_uses_rt && (id_rt == ex_rd);
      return ex_memread && (ex_rd != 5'd0) && (rs_dep || rt_dep);
   endfunction

   // Order: pc, ifid, idex, exmem, memwb, ifid_clr, idex_clr, bubble.
   function automatic logic [7:0] exp_outs();
      if (reset)           return 8'b00000_110;
      if (m_frozen())      return 8'b00000_000;
      if (ex_branch_taken) return 8'b10011_110;
      if (m_hazard())      return 8'b00111_011;
      return 8'b11111_000;
   endfunction

   task automatic model_advance();
      logic [7:0] o;
      bit         frz;
      o   = exp_outs();
      frz = m_frozen();
      if (reset) begin
         m_in_access = 0;
         m_age       = 0;
         m_stall     = '0;
         m_flush     = '0;
      end else begin
         if (!o[7] && m_stall != '1) m_stall = m_stall + 1'b1;
         if (!frz && ex_branch_taken && m_flush != '1) m_flush = m_flush + 1'b1;
         if (m_in_access) begin
            if (m_age == int'(MEM_LAT) - 1) m_in_access = 0;
            else m_age++;
         end else if (mem_access && MEM_LAT > 1) begin
            m_in_access = 1;
            m_age       = 1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_advance();
      #1;
   endtask

   task automatic idle();
      reset           = 1'b0;
      id_rs           = 5'd0;
      id_rt           = 5'd0;
      id_uses_rs      = 1'b0;
      id_uses_rt      = 1'b0;
      ex_memread      = 1'b0;
      ex_rd           = 5'd0;
      ex_branch_taken = 1'b0;
      mem_access      = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (act_outs() !== 8'b00000_110) begin
            errors++;
            $display("FAIL reset_outs cyc %0d: got %b want %b", i, act_outs(), 8'b00000_110);
         end
         checks++;
         if (i > 0 && {stall_cycles, flush_count} !== 8'h00) begin
            errors++;
            $display("FAIL reset_counters cyc %0d: got %h/%h want 0/0", i, stall_cycles,
                     flush_count);
         end
         if (i > 0) checks++;
         tick();
      end
      reset = 1'b0;
      @(negedge clk);
      if (act_outs() !== exp_outs()) begin
         errors++;
         $display("FAIL reset_release: got %b want %b", act_outs(), exp_outs());
      end
      checks++;
      tick();
   endtask

   task automatic test_load_use();
      idle();
      ex_memread = 1'b1;
      ex_rd      = 5'd8;
      id_rs      = 5'd8;
      id_uses_rs = 1'b1;
      @(negedge clk);
      if (act_outs() !== exp_outs()) begin
         errors++;
         $display("FAIL load_use_outs: got %b want %b", act_outs(), exp_outs());
      end
      checks++;
      tick();
      idle();
      @(negedge clk);
      if (stall_cycles !== 4'd1 || act_outs() !== exp_outs()) begin
         errors++;
         $display("FAIL load_use_after: stall=%0d outs=%b want stall=1 outs=%b", stall_cycles,
                  act_outs(), exp_outs());
      end
      checks++;
      tick();
   endtask

   task automatic test_exclusions();
      for (int k = 0; k < 2; k++) begin
         idle();
         ex_memread = 1'b1;
         if (k == 0) begin
            ex_rd      = 5'd0;
            id_rs      = 5'd0;
            id_uses_rs = 1'b1;
         end else begin
            ex_rd      = 5'd8;
            id_rt      = 5'd8;
            id_uses_rt = 1'b0;
         end
         @(negedge clk);
         if (act_outs() !== 8'b11111_000) begin
            errors++;
            $display("FAIL exclusion_%0d: got %b want %b", k, act_outs(), 8'b11111_000);
         end
         checks++;
         tick();
      end
   endtask

   task automatic test_branch_vs_load_use();
      logic [CNT_W-1:0] stall_before;
      idle();
      @(negedge clk);
      stall_before    = m_stall;
      ex_memread      = 1'b1;
      ex_rd           = 5'd8;
      id_rs           = 5'd8;
      id_uses_rs      = 1'b1;
      ex_branch_taken = 1'b1;
      #1;
      if (act_outs() !== 8'b10011_110) begin
         errors++;
         $display("FAIL branch_over_hazard: got %b want %b", act_outs(), 8'b10011_110);
      end
      checks++;
      tick();
      idle();
      @(negedge clk);
      if (flush_count !== m_flush || stall_cycles !== stall_before) begin
         errors++;
         $display("FAIL branch_counters: flush=%0d stall=%0d want flush=%0d stall=%0d",
                  flush_count, stall_cycles, m_flush, stall_before);
      end
      checks++;
      tick();
   endtask

   // pass 0: plain access; pass 1: branch held in EX for the whole access.
   task automatic test_mem_stall();
      logic [CNT_W-1:0] stall_before, flush_before;
      for (int pass = 0; pass < 2; pass++) begin
         idle();
         @(negedge clk);
         stall_before = stall_cycles;
         flush_before = flush_count;
         for (int c = 0; c < int'(MEM_LAT); c++) begin
            mem_access      = (c == 0);
            ex_branch_taken = (pass == 1);
            #1;
            if (act_outs() !== exp_outs()) begin
               errors++;
               $display("FAIL mem_stall p%0d c%0d: got %b want %b", pass, c, act_outs(),
                        exp_outs());
            end
            checks++;
            tick();
            @(negedge clk);
         end
         idle();
         #1;
         if (stall_cycles !== stall_before + 4'(MEM_LAT - 1)
             || flush_count !== flush_before + 4'(pass)) begin
            errors++;
            $display("FAIL mem_stall_cnt p%0d: stall=%0d flush=%0d want stall=%0d flush=%0d",
                     pass, stall_cycles, flush_count, stall_before + 4'(MEM_LAT - 1),
                     flush_before + 4'(pass));
         end
         checks++;
         tick();
      end
   endtask

   task automatic test_reset_midwait();
      idle();
      mem_access = 1'b1;
      tick();
      mem_access = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      if (act_outs() !== 8'b11111_000 || {stall_cycles, flush_count} !== 8'h00) begin
         errors++;
         $display("FAIL reset_midwait: outs=%b cnt=%h/%h want %b 0/0", act_outs(),
                  stall_cycles, flush_count, 8'b11111_000);
      end
      checks++;
      tick();
   endtask

   task automatic test_saturation();
      idle();
      reset = 1'b1;
      tick();
      reset      = 1'b0;
      ex_memread = 1'b1;
      ex_rd      = 5'd3;
      id_rt      = 5'd3;
      id_uses_rt = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      @(negedge clk);
      if (stall_cycles !== 4'd15) begin
         errors++;
         $display("FAIL saturation: stall=%0d want 15", stall_cycles);
      end
      checks++;
      tick();
      idle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         reset           = ($urandom_range(0, 39) == 0);
         id_rs           = 5'($urandom_range(0, 3));
         id_rt           = 5'($urandom_range(0, 3));
         ex_rd           = 5'($urandom_range(0, 3));
         id_uses_rs      = 1'($urandom);
         id_uses_rt      = 1'($urandom);
         ex_memread      = 1'($urandom);
         ex_branch_taken = ($urandom_range(0, 4) == 0);
         mem_access      = ($urandom_range(0, 5) == 0);
         @(negedge clk);
         if (act_outs() !== exp_outs()) begin
            errors++;
            $display("FAIL random_outs %0d: got %b want %b", i, act_outs(), exp_outs());
         end
         if (stall_cycles !== m_stall || flush_count !== m_flush) begin
            errors++;
            $display("FAIL random_cnt %0d: got %0d/%0d want %0d/%0d", i, stall_cycles,
                     flush_count, m_stall, m_flush);
         end
         checks += 2;
         tick();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_exclusions();
      test_branch_vs_load_use();
      test_mem_stall();
      test_reset_midwait();
      test_saturation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
